// File: rtl/deltaacc_config_master.sv
`default_nettype none
// ============================================================================
// Module   : deltaacc_config_master
// Purpose  : Bus-initiator sequencer that programs one DeltaAcc layer. It
//            takes a nine-word descriptor, writes config words 1..8, then
//            word 0 with the start bit forced, polls status bit 0[31] until
//            done (or an optional timeout), and pulses the outcome.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            i_cmd_valid/o_cmd_ready/i_cmd_regs - descriptor handshake
//            i_abort             - synchronous cancel back to idle
//            o_busy              - transaction in progress
//            o_layer_done/o_timeout - one-cycle completion pulses
//            o_status_word       - last word-0 value read from the slave
//            o_chipselect/o_read/o_write/o_address/o_writedata/i_readdata
//                                - register-slave bus
// Revision : 1.0 - initial release
// ============================================================================
module deltaacc_config_master #(
  parameter int unsigned POLL_INTERVAL  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [287:0]  i_cmd_regs,
  input  logic          i_abort,
  output logic          o_busy,
  output logic          o_layer_done,
  output logic          o_timeout,
  output logic [31:0]   o_status_word,
  output logic          o_chipselect,
  output logic          o_read,
  output logic          o_write,
  output logic [3:0]    o_address,
  output logic [31:0]   o_writedata,
  input  logic [31:0]   i_readdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_WAIT   = 3'd2,
    S_READ   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [31:0] c_poll_last = 32'(POLL_INTERVAL - 1);
  localparam logic [31:0] c_to_limit  = 32'(TIMEOUT_CYCLES);

  state_t        r_state;
  logic [3:0]    r_addr_cnt;
  logic [31:0]   r_poll_cnt;
  logic [31:0]   r_to_cnt;
  logic [287:0]  r_snap;
  logic [31:0]   r_status;
  logic          r_cs;
  logic          r_rd;
  logic          r_wr;
  logic [3:0]    r_address;
  logic [31:0]   r_wdata;
  logic          r_done;
  logic          r_to_pulse;

  state_t        w_state_nxt;
  logic [3:0]    w_addr_nxt;
  logic [31:0]   w_poll_nxt;
  logic [31:0]   w_to_nxt;
  logic          w_snap_load;
  logic          w_status_load;
  logic          w_fin_to;
  logic [31:0]   w_to_inc;
  logic          w_to_hit;
  logic [31:0]   w_src_words [9];
  logic          w_cs_nxt;
  logic          w_rd_nxt;
  logic          w_wr_nxt;
  logic [3:0]    w_address_nxt;
  logic [31:0]   w_wdata_nxt;

  assign w_to_inc = r_to_cnt + 32'd1;
  assign w_to_hit = (TIMEOUT_CYCLES != 0) && (w_to_inc == c_to_limit);

  // The first write is issued in the cycle right after acceptance, before the
  // snapshot register holds the descriptor, so the word source bypasses to
  // the live input on the accepting edge.
  generate
    for (genvar k = 0; k < 9; k++) begin : g_word
      assign w_src_words[k] = w_snap_load ? i_cmd_regs[32*k +: 32]
                                          : r_snap[32*k +: 32];
    end
  endgenerate

  // Next-state and counter control
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr_cnt;
    w_poll_nxt    = r_poll_cnt;
    w_to_nxt      = r_to_cnt;
    w_snap_load   = 1'b0;
    w_status_load = 1'b0;
    w_fin_to      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_state_nxt = S_WRITE;
          w_addr_nxt  = 4'd1;
          w_snap_load = 1'b1;
        end
      end
      S_WRITE: begin
        if (r_addr_cnt == 4'd0) begin
          w_state_nxt = S_WAIT;
          w_poll_nxt  = '0;
          w_to_nxt    = '0;
        end else if (r_addr_cnt == 4'd8) begin
          w_addr_nxt = 4'd0;
        end else begin
          w_addr_nxt = r_addr_cnt + 4'd1;
        end
      end
      S_WAIT: begin
        w_to_nxt = w_to_inc;
        if (w_to_hit) begin
          w_state_nxt = S_FINISH;
          w_fin_to    = 1'b1;
        end else if (r_poll_cnt == c_poll_last) begin
          w_state_nxt = S_READ;
        end else begin
          w_poll_nxt = r_poll_cnt + 32'd1;
        end
      end
      S_READ: begin
        w_to_nxt      = w_to_inc;
        w_status_load = 1'b1;
        // Done observed on the expiry edge takes precedence over timeout.
        if (i_readdata[31]) begin
          w_state_nxt = S_FINISH;
        end else if (w_to_hit) begin
          w_state_nxt = S_FINISH;
          w_fin_to    = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
          w_poll_nxt  = '0;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nxt   = S_IDLE;
      w_status_load = 1'b0;
      w_fin_to      = 1'b0;
    end
  end

  // Bus and pulse outputs are registered, so they are decoded from the
  // state being entered rather than the current one.
  always_comb begin
    w_cs_nxt      = 1'b0;
    w_rd_nxt      = 1'b0;
    w_wr_nxt      = 1'b0;
    w_address_nxt = 4'd0;
    w_wdata_nxt   = 32'd0;
    if (w_state_nxt == S_WRITE) begin
      w_cs_nxt      = 1'b1;
      w_wr_nxt      = 1'b1;
      w_address_nxt = w_addr_nxt;
      if (w_addr_nxt == 4'd0) begin
        // Clear the done bit and force the start bit on the control write.
        w_wdata_nxt = {1'b0, w_src_words[0][30:1], 1'b1};
      end else begin
        w_wdata_nxt = w_src_words[w_addr_nxt];
      end
    end else if (w_state_nxt == S_READ) begin
      w_cs_nxt = 1'b1;
      w_rd_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_cnt <= 4'd0;
      r_poll_cnt <= 32'd0;
      r_to_cnt   <= 32'd0;
      r_snap     <= '0;
      r_status   <= 32'd0;
      r_cs       <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_address  <= 4'd0;
      r_wdata    <= 32'd0;
      r_done     <= 1'b0;
      r_to_pulse <= 1'b0;
    end else begin
      r_addr_cnt <= w_addr_nxt;
      r_poll_cnt <= w_poll_nxt;
      r_to_cnt   <= w_to_nxt;
      if (w_snap_load) begin
        r_snap <= i_cmd_regs;
      end
      if (w_status_load) begin
        r_status <= i_readdata;
      end
      r_cs       <= w_cs_nxt;
      r_rd       <= w_rd_nxt;
      r_wr       <= w_wr_nxt;
      r_address  <= w_address_nxt;
      r_wdata    <= w_wdata_nxt;
      r_done     <= (w_state_nxt == S_FINISH) && !w_fin_to;
      r_to_pulse <= (w_state_nxt == S_FINISH) && w_fin_to;
    end
  end

  assign o_cmd_ready   = (r_state == S_IDLE);
  assign o_busy        = (r_state != S_IDLE);
  assign o_layer_done  = r_done;
  assign o_timeout     = r_to_pulse;
  assign o_status_word = r_status;
  assign o_chipselect  = r_cs;
  assign o_read        = r_rd;
  assign o_write       = r_wr;
  assign o_address     = r_address;
  assign o_writedata   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_deltaacc_config_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_deltaacc_config_master
// Purpose  : Self-checking bench for deltaacc_config_master. A slave model
//            answers the register bus; expected bus traffic, poll count and
//            completion cycle are derived arithmetically per transaction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_deltaacc_config_master;

  localparam int P  = 4;
  localparam int TO = 50;
  localparam int NEVER = 1000000;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [287:0] cmd_regs;
  logic         abort;
  logic         busy;
  logic         layer_done;
  logic         timeout;
  logic [31:0]  status_word;
  logic         cs;
  logic         rd;
  logic         wr;
  logic [3:0]   address;
  logic [31:0]  wdata;
  logic [31:0]  readdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave model
  logic [31:0] s_reg0 = 32'd0;
  bit          s_active = 1'b0;
  int          s_cnt = 0;
  int          s_delay = NEVER;

  // monitor logs
  logic [37:0] bus_q[$];
  int          bus_cyc[$];
  int          done_q[$];
  int          to_q[$];

  logic [31:0] exp_status;

  deltaacc_config_master #(
    .POLL_INTERVAL (P),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_regs   (cmd_regs),
    .i_abort      (abort),
    .o_busy       (busy),
    .o_layer_done (layer_done),
    .o_timeout    (timeout),
    .o_status_word(status_word),
    .o_chipselect (cs),
    .o_read       (rd),
    .o_write      (wr),
    .o_address    (address),
    .o_writedata  (wdata),
    .i_readdata   (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Writing register 0 restarts the slave's done timer; done reads as 1 once
  // s_delay cycles have passed since that write.
  always @(posedge clk) begin
    if (cs && wr && address == 4'd0) begin
      s_reg0   <= wdata;
      s_active <= 1'b1;
      s_cnt    <= 0;
    end else if (s_active && s_cnt < NEVER) begin
      s_cnt <= s_cnt + 1;
    end
  end
  assign readdata = {(s_active && s_cnt >= s_delay), s_reg0[30:0]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cs) begin
        bus_q.push_back({wr, rd, address, wdata});
        bus_cyc.push_back(cyc);
      end
      if (layer_done) done_q.push_back(cyc);
      if (timeout) to_q.push_back(cyc);
      if (cs || rd || wr || layer_done || timeout)
        chk("protocol", {!(rd && wr), cs == (rd || wr), !(layer_done && timeout)}, 3'b111);
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pulses"}, {layer_done, timeout}, 0);
    chk({tag, "_strobes"}, {cs, rd, wr}, 0);
    chk({tag, "_addr"}, address, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_status"}, status_word, 0);
  endtask

  function automatic logic [287:0] rand_desc();
    logic [287:0] d;
    for (int k = 0; k < 9; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  // mode 0: run to completion; 1: abort while writing address ab_addr;
  // 2: async reset while waiting between polls.
  task automatic run_txn(input logic [287:0] d, input int delay, input int mode, input int ab_addr);
    int T, n, rc, nreads, fin_off, nbus;
    bit is_to;
    logic [31:0] w0wr, ed;
    logic [5:0] eh;
    @(negedge clk);
    chk("ready_before", cmd_ready, 1);
    bus_q.delete(); bus_cyc.delete(); done_q.delete(); to_q.delete();
    s_delay   = delay;
    cmd_regs  = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    T = cyc;
    cmd_valid = 1'b0;
    cmd_regs  = rand_desc();

    // reference: poll i occurs in the cycle T+9+P+i*(P+1); the timeout
    // expires at edge T+9+TO; a poll sees done when its offset >= delay.
    w0wr = {1'b0, d[30:1], 1'b1};
    nreads = 0; is_to = 1'b0; fin_off = 0;
    for (int i = 0; i < 1000; i++) begin
      rc = P + i * (P + 1);
      if (TO != 0 && rc >= TO) begin is_to = 1'b1; fin_off = TO; break; end
      nreads = i + 1;
      if (rc >= delay) begin fin_off = rc + 1; break; end
    end

    nbus = 9;
    if (mode == 0) begin
      n = 0;
      while (done_q.size() + to_q.size() == 0 && n < 400) begin @(negedge clk); n++; end
      chk("finish_seen", n < 400, 1);
      repeat (3) @(negedge clk);
      nbus = 9 + nreads;
      if (is_to) begin
        chk("to_count", to_q.size(), 1);
        chk("done_count", done_q.size(), 0);
        if (to_q.size() == 1) chk("to_cycle", to_q[0], T + 9 + fin_off);
      end else begin
        chk("done_count", done_q.size(), 1);
        chk("to_count", to_q.size(), 0);
        if (done_q.size() == 1) chk("done_cycle", done_q[0], T + 9 + fin_off);
      end
      exp_status = {!is_to, w0wr[30:0]};
      chk("ready_after", {cmd_ready, busy}, 2'b10);
    end else if (mode == 1) begin
      n = 0;
      while (!(wr && address == 4'(ab_addr)) && n < 20) begin @(negedge clk); n++; end
      chk("abort_point_found", n < 20, 1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_bus_idle", {cs, rd, wr}, 0);
      chk("abort_ready", {cmd_ready, busy}, 2'b10);
      repeat (30) @(negedge clk);
      nbus = ab_addr;
      chk("abort_no_pulse", done_q.size() + to_q.size(), 0);
    end else begin
      repeat (12) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      exp_status = 32'd0;
      chk("rst_no_pulse", done_q.size() + to_q.size(), 0);
    end

    chk("bus_count", bus_q.size(), nbus);
    for (int i = 0; i < bus_q.size() && i < nbus; i++) begin
      if (i < 9) begin
        eh = {2'b10, (i < 8) ? 4'(i + 1) : 4'd0};
        ed = (i < 8) ? d[(i + 1) * 32 +: 32] : w0wr;
        chk("write_kind_addr", bus_q[i][37:32], eh);
        chk("write_data", bus_q[i][31:0], ed);
        chk("write_cycle", bus_cyc[i], T + i);
      end else begin
        chk("read_kind_addr", bus_q[i][37:32], 6'b010000);
        chk("read_cycle", bus_cyc[i], T + 9 + P + (i - 9) * (P + 1));
      end
    end
    chk("status_word", status_word, exp_status);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [287:0] d;
    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_regs = '0;
    exp_status = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // words 0x100+k, done 40 cycles after start
    for (int k = 0; k < 9; k++) d[32*k +: 32] = 32'h100 + k;
    run_txn(d, 40, 0, 0);

    // done already set before the first poll
    run_txn(rand_desc(), 2, 0, 0);

    // word0 all-ones in bit 31 only: control write must be 1
    d = rand_desc();
    d[31:0] = 32'h8000_0000;
    run_txn(d, 10, 0, 0);
    chk("w0_top_bit_status", status_word, 32'h8000_0001);

    // done never arrives -> timeout
    run_txn(rand_desc(), NEVER, 0, 0);

    // abort while address 4 is on the bus
    run_txn(rand_desc(), 40, 1, 4);

    // async reset while waiting, then a full replay
    run_txn(rand_desc(), 40, 2, 0);
    run_txn(rand_desc(), 40, 0, 0);

    // random descriptors and done latencies
    for (int t = 0; t < 6; t++) run_txn(rand_desc(), int'($urandom_range(0, 60)), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
